// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped, transmit-only console UART.
// CPU stores in the 16-byte window at BASE feed an 8-entry byte FIFO.
// The FIFO drains through an 8N1 serialiser onto tx.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset      synchronous active-high reset
//   address    CPU data address (window hit on address[31:4])
//   writeData  CPU store data (TXDATA uses [7:0], DIVISOR uses [15:0])
//   mode       access size; unused, only the low byte lane matters
//   memRead    CPU load strobe, gates readData
//   memWrite   CPU store strobe, committed on the rising edge
//   readData   combinational register read data, 0 unless selected and read
//   sel        combinational window hit
//   tx         serial output, idle high
//   irq        registered, high while FIFO empty and serialiser idle
//
// Register map (offset = address[3:0]):
//   0x0 TXDATA  W   push byte; dropped (DROPCNT++) when full
//   0x4 STATUS  R   {count[7:4], 0, busy, empty, full}
//   0x8 DIVISOR RW  clk cycles per bit, 0 stores 1
//   0xC DROPCNT R   saturating drop count; any write clears
//
// Serialiser states:
//   state   | meaning
//   S_IDLE  | line high, waiting for a FIFO byte
//   S_START | start bit (tx=0)
//   S_DATA  | data bits, LSB first, r_bitcnt = current bit
//   S_STOP  | stop bit (tx=1); may pop and restart without an idle gap
module mmio_uart_tx #(
  parameter logic [31:0] BASE       = 32'hFFFF_0000,
  parameter int          DEPTH_LOG2 = 3,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic [1:0]  mode,
  input  logic        memRead,
  input  logic        memWrite,
  output logic [31:0] readData,
  output logic        sel,
  output logic        tx,
  output logic        irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                r_state;
  logic [15:0]           r_baud;
  logic [2:0]            r_bitcnt;
  logic [7:0]            r_shift;
  logic                  r_tx;
  logic                  r_irq;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [15:0]           r_div;
  logic [7:0]            r_dropcnt;

  logic          w_sel;
  logic [3:0]    w_off;
  logic          w_wr_txdata;
  logic          w_wr_div;
  logic          w_wr_drop;
  logic          w_empty;
  logic          w_full;
  logic          w_baud_done;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [CW-1:0] w_count_nxt;
  logic          w_idle_nxt;
  logic [7:0]    w_head;
  logic [31:0]   w_status;
  logic          w_unused;

  assign w_sel       = (address[31:4] == BASE[31:4]);
  assign w_off       = address[3:0];
  assign w_wr_txdata = memWrite && w_sel && (w_off == 4'h0);
  assign w_wr_div    = memWrite && w_sel && (w_off == 4'h8);
  assign w_wr_drop   = memWrite && w_sel && (w_off == 4'hC);

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == FULL_CNT);
  assign w_baud_done = (r_baud == 16'd0);

  // Pop only from IDLE or at the end of a stop bit; either way the start bit
  // begins on the same edge.
  assign w_pop  = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_done));
  // A pop in the same cycle frees a slot, so a store into a full FIFO is kept.
  assign w_push = w_wr_txdata && (!w_full || w_pop);
  assign w_drop = w_wr_txdata && !w_push;

  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  // The serialiser is IDLE after this edge only if nothing was available to pop.
  assign w_idle_nxt  = w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_done));
  assign w_head      = r_mem[r_rd_ptr];

  assign w_status = (32'(r_count) << 4) |
                    {29'd0, (r_state != S_IDLE), w_empty, w_full};

  always_comb begin
    readData = 32'd0;
    if (w_sel && memRead) begin
      case (w_off)
        4'h4:    readData = w_status;
        4'h8:    readData = {16'd0, r_div};
        4'hC:    readData = {24'd0, r_dropcnt};
        default: readData = 32'd0;
      endcase
    end
  end

  assign sel = w_sel;
  assign tx  = r_tx;
  assign irq = r_irq;

  // Only the low byte lane is meaningful; access size is irrelevant here.
  assign w_unused = ^{mode, writeData[31:16]};

  // FIFO storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= writeData[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_div     <= DIV_RESET;
      r_dropcnt <= 8'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      if (w_wr_div) r_div <= (writeData[15:0] == 16'd0) ? 16'd1 : writeData[15:0];
      // A clearing write wins over a same-cycle drop.
      if (w_wr_drop)                          r_dropcnt <= 8'd0;
      else if (w_drop && r_dropcnt != 8'hFF)  r_dropcnt <= r_dropcnt + 8'd1;
    end
  end

  // r_div is sampled only when the baud counter reloads, so a DIVISOR write
  // mid-bit takes effect at the next bit boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_baud   <= 16'd0;
      r_bitcnt <= 3'd0;
      r_shift  <= 8'd0;
      r_tx     <= 1'b1;
      r_irq    <= 1'b1;
    end else begin
      r_irq <= (w_count_nxt == '0) && w_idle_nxt;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= w_head;
            r_tx    <= 1'b0;
            r_baud  <= r_div - 16'd1;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_baud_done) begin
            r_tx     <= r_shift[0];
            r_shift  <= r_shift >> 1;
            r_bitcnt <= 3'd0;
            r_baud   <= r_div - 16'd1;
            r_state  <= S_DATA;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud <= r_div - 16'd1;
            if (r_bitcnt == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bitcnt <= r_bitcnt + 3'd1;
              r_tx     <= r_shift[0];
              r_shift  <= r_shift >> 1;
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        S_STOP: begin
          if (w_baud_done) begin
            if (w_pop) begin
              r_shift <= w_head;
              r_tx    <= 1'b0;
              r_baud  <= r_div - 16'd1;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [1:0]  mode;
  logic        memRead;
  logic        memWrite;
  logic [31:0] readData;
  logic        sel;
  logic        tx;
  logic        irq;

  always #5 clk = ~clk;

  mmio_uart_tx dut (
    .clk(clk), .reset(reset), .address(address), .writeData(writeData),
    .mode(mode), .memRead(memRead), .memWrite(memWrite),
    .readData(readData), .sel(sel), .tx(tx), .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: a byte queue plus the edge at which the line is free
  // again. A frame is popped at the first edge where the queue is non-empty
  // and the previous frame's 10*DIVISOR cycles have elapsed.
  typedef struct {
    logic [7:0] b;
    int         edge_no;
    int         div;
  } frame_t;

  frame_t     exp_q[$];
  logic [7:0] mq[$];
  int         cyc = 0;
  int         free_edge = 0;
  int         m_div = 16;
  int         m_drops = 0;
  bit         m_hit;
  frame_t     m_fr;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      mq.delete();
      exp_q.delete();
      free_edge = 0;
      m_div = 16;
      m_drops = 0;
    end else begin
      m_hit = memWrite && (address[31:4] == BASE[31:4]);
      if (mq.size() > 0 && cyc >= free_edge) begin
        m_fr.b = mq.pop_front();
        m_fr.edge_no = cyc;
        m_fr.div = m_div;
        exp_q.push_back(m_fr);
        free_edge = cyc + 10 * m_div;
      end
      if (m_hit && address[3:0] == 4'h0) begin
        if (mq.size() < 8) mq.push_back(writeData[7:0]);
        else if (m_drops < 255) m_drops++;
      end
      if (m_hit && address[3:0] == 4'h8)
        m_div = (writeData[15:0] == 16'd0) ? 1 : int'(writeData[15:0]);
      if (m_hit && address[3:0] == 4'hC) m_drops = 0;
    end
  end

  // Monitor: decodes frames off tx and checks them against the queue.
  bit         mon_en = 0;
  bit         mon_busy = 0;
  frame_t     mon_fr;
  logic [7:0] mon_b;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        mon_busy = 1;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
          for (int n = 0; n < 400 && tx === 1'b0; n++) @(negedge clk);
        end else begin
          mon_fr = exp_q.pop_front();
          chk("frame_start_edge", cyc, mon_fr.edge_no);
          mon_b = 8'h00;
          for (int i = 0; i < 8; i++) begin
            repeat (mon_fr.div) @(negedge clk);
            mon_b[i] = tx;
          end
          repeat (mon_fr.div) @(negedge clk);
          chk("stop_bit", {31'd0, tx}, 32'd1);
          repeat (mon_fr.div - 1) @(negedge clk);
          chk("frame_byte", {24'd0, mon_b}, {24'd0, mon_fr.b});
        end
        mon_busy = 0;
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writeData = d; memWrite = 1'b1;
    @(posedge clk);
    #1 memWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; memRead = 1'b1;
    #1 d = readData;
    memRead = 1'b0;
  endtask

  task automatic check_status(input string tag);
    logic [31:0] st, dc, exp_st;
    bit busy;
    @(negedge clk);
    busy = (cyc < free_edge);
    exp_st = (32'(mq.size()) << 4) | {29'd0, busy, mq.size() == 0, mq.size() == 8};
    memRead = 1'b1;
    address = BASE + 32'h4;
    #1 st = readData;
    address = BASE + 32'hC;
    #1 dc = readData;
    memRead = 1'b0;
    chk({tag, "_status"}, st, exp_st);
    chk({tag, "_dropcnt"}, dc, 32'(m_drops));
    chk({tag, "_irq"}, {31'd0, irq}, {31'd0, (!busy && mq.size() == 0)});
  endtask

  task automatic drain();
    int n = 0;
    while (!(mq.size() == 0 && exp_q.size() == 0 && cyc >= free_edge && !mon_busy) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", {31'd0, n < 6000}, 32'd1);
  endtask

  logic [31:0] r;
  logic [15:0] txs;
  logic [15:0] exp_tx;
  int          n0;
  int          target;

  initial begin
    reset = 1'b1; address = 32'd0; writeData = 32'd0; mode = 2'd0;
    memRead = 1'b0; memWrite = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);

    // Reset state
    @(negedge clk);
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_irq", {31'd0, irq}, 32'd1);
    rd(BASE + 32'h4, r); chk("reset_status", r, 32'h0000_0002);
    rd(BASE + 32'h8, r); chk("reset_divisor", r, 32'd16);
    rd(BASE + 32'hC, r); chk("reset_dropcnt", r, 32'd0);

    // Single frame, DIVISOR=4
    wr(BASE + 32'h8, 32'd4);
    mon_en = 1;
    wr(BASE, 32'h0000_00A5);
    drain();
    chk("a5_irq_after", {31'd0, irq}, 32'd1);
    check_status("a5");

    // Back-to-back fill at DIVISOR=2, tenth store dropped
    wr(BASE + 32'h8, 32'd2);
    for (int i = 0; i < 10; i++) wr(BASE, 32'h30 + i);
    rd(BASE + 32'h4, r); chk("fill_status", r, 32'h0000_0085);
    rd(BASE + 32'hC, r); chk("fill_dropcnt", r, 32'd1);
    check_status("fill");

    // Store into full FIFO on the STOP->START pop edge
    target = free_edge;
    do @(negedge clk); while (cyc < target - 1);
    chk("popedge_align", cyc, target - 1);
    address = BASE; writeData = 32'h3A; memWrite = 1'b1;
    @(posedge clk);
    #1 memWrite = 1'b0;
    rd(BASE + 32'h4, r); chk("popedge_status", r, 32'h0000_0085);
    rd(BASE + 32'hC, r); chk("popedge_dropcnt", r, 32'd1);
    drain();

    // DIVISOR 0 stores 1
    wr(BASE + 32'h8, 32'd0);
    rd(BASE + 32'h8, r); chk("div_zero", r, 32'd1);

    // Mid-frame divisor change then reset during data bit 3
    wr(BASE + 32'h8, 32'd4);
    mon_en = 0;
    wr(BASE, 32'h55);
    n0 = cyc;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      txs[k-1] = tx;
      if (k == 6)  begin address = BASE + 32'h8; writeData = 32'd3;  memWrite = 1'b1; end
      if (k == 7)  begin address = BASE;         writeData = 32'h77; memWrite = 1'b1; end
      if (k == 16) reset = 1'b1;
      @(posedge clk);
      #1 memWrite = 1'b0; reset = 1'b0;
    end
    chk("midframe_edges", cyc - n0, 32'd16);
    // Idle 1, start 4, bit0 4 (old timing), bit1 3, bit2 3, bit3 first cycle.
    exp_tx = 16'h0;
    begin
      int p = 0;
      int lv[6] = '{1, 0, 1, 0, 1, 0};
      int ln[6] = '{1, 4, 4, 3, 3, 1};
      for (int s = 0; s < 6; s++)
        for (int j = 0; j < ln[s]; j++) begin
          exp_tx[p] = lv[s][0];
          p++;
        end
    end
    for (int j = 0; j < 16; j++)
      chk($sformatf("midframe_tx[%0d]", j), {31'd0, txs[j]}, {31'd0, exp_tx[j]});

    @(negedge clk);
    chk("abort_tx", {31'd0, tx}, 32'd1);
    chk("abort_irq", {31'd0, irq}, 32'd1);
    memRead = 1'b1;
    address = BASE + 32'h4; #1 chk("abort_status", readData, 32'h0000_0002);
    address = BASE + 32'hC; #1 chk("abort_dropcnt", readData, 32'd0);
    address = BASE + 32'h8; #1 chk("abort_divisor", readData, 32'd16);
    memRead = 1'b0;

    // Out-of-window store
    @(negedge clk);
    address = 32'h0000_0010; writeData = 32'h42; memWrite = 1'b1;
    #1 chk("outside_sel", {31'd0, sel}, 32'd0);
    @(posedge clk);
    #1 memWrite = 1'b0;
    rd(BASE + 32'h4, r); chk("outside_status", r, 32'h0000_0002);
    chk("outside_tx", {31'd0, tx}, 32'd1);
    check_status("outside");

    // Randomized traffic
    wr(BASE + 32'h8, $urandom_range(1, 4));
    mon_en = 1;
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 11))
        0, 1, 2, 3, 4, 5: wr(BASE, {24'd0, 8'($urandom)});
        6:  wr(BASE + 32'h4, $urandom);
        7:  wr(BASE + 32'hC, $urandom);
        8:  wr(32'h0000_1000, $urandom);
        9:  check_status("rand");
        default: @(negedge clk);
      endcase
    end
    drain();
    check_status("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
